// File: rtl/clint_mh.sv
// clint_mh: multi-hart core-local interruptor.
// One shared 64-bit mtime driven by a TICK_DIV prescaler, plus per-hart msip,
// 64-bit mtimecmp, timer/software interrupt outputs and a 2-flop external
// interrupt synchroniser.
// Optional feature macro: CLINT_MH_MTIME_WR_EN makes the mtime words writable;
// without it mtime is read-only and writes to it are acknowledged and dropped.
//
// Handshake: a request (wready or rready) sampled high at a rising edge is
// serviced at that edge, and its acknowledge (wvalid or rvalid) is high for
// exactly the following cycle. Requests are never stalled, so back-to-back
// requests each get their own one-cycle acknowledge. Read data is taken from
// register values before any same-edge write.
module clint_mh #(
  parameter int NHART    = 2,
  parameter int TICK_DIV = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              timer_en,
  input  logic              wready,
  output logic              wvalid,
  input  logic [31:0]       waddr,
  input  logic [31:0]       wdata,
  input  logic [3:0]        wstrb,
  input  logic              rready,
  output logic              rvalid,
  input  logic [31:0]       raddr,
  output logic              rresp,
  output logic [31:0]       rdata,
  input  logic [NHART-1:0]  ext_irq_in,
  output logic [NHART-1:0]  timer_irq,
  output logic [NHART-1:0]  sw_irq,
  output logic [NHART-1:0]  ex_irq
);

  localparam int            PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

  // Word indices of the mtime low/high registers (0xBFF8 and 0xBFFC).
  localparam logic [13:0] MTIME_LO_WORD = 14'h2FFE;
  localparam logic [13:0] MTIME_HI_WORD = 14'h2FFF;

  // Byte-lane merge of a 32-bit write into an existing word.
  function automatic logic [31:0] f_merge(input logic [31:0] i_old,
                                          input logic [31:0] i_new,
                                          input logic [3:0]  i_strb);
    logic [31:0] v;
    v = i_old;
    for (int b = 0; b < 4; b++) begin
      if (i_strb[b]) v[8*b +: 8] = i_new[8*b +: 8];
    end
    return v;
  endfunction

  // State
  logic [PW-1:0]    r_presc;
  logic [63:0]      r_mtime;
  logic [63:0]      r_mtimecmp [NHART];
  logic [NHART-1:0] r_msip;
  logic             r_wvalid;
  logic             r_rvalid;
  logic             r_rresp;
  logic [31:0]      r_rdata;
  logic [NHART-1:0] r_timer_irq;
  logic [NHART-1:0] r_sw_irq;
  logic [NHART-1:0] r_ext_meta;
  logic [NHART-1:0] r_ex_irq;

  // Decode
  logic [13:0] w_wr_word;
  logic [10:0] w_wr_cmp_idx;
  logic        w_wr_msip;
  logic        w_wr_cmp;
  logic        w_tick;
  logic [63:0] w_mtime_nxt;
  logic [13:0] w_rd_word;
  logic [10:0] w_rd_cmp_idx;
  logic [31:0] w_rd_data;
  logic        w_rd_err;
  logic        w_unused;

  assign w_wr_word    = waddr[15:2];
  assign w_wr_cmp_idx = waddr[13:3];
  assign w_wr_msip    = wready && (w_wr_word < 14'(NHART));
  assign w_wr_cmp     = wready && (waddr[15:14] == 2'b01) &&
                        (w_wr_cmp_idx < 11'(NHART));
  assign w_rd_word    = raddr[15:2];
  assign w_rd_cmp_idx = raddr[13:3];

  // The increment happens on the last prescaler count of an enabled cycle.
  assign w_tick = timer_en && (r_presc == PMAX);

  // Upper address bits and the byte offset do not take part in decoding.
  assign w_unused = &{1'b0, waddr[31:16], waddr[1:0], raddr[31:16], raddr[1:0]};

`ifdef CLINT_MH_MTIME_WR_EN
  logic w_wr_mtlo;
  logic w_wr_mthi;
  assign w_wr_mtlo = wready && (w_wr_word == MTIME_LO_WORD);
  assign w_wr_mthi = wready && (w_wr_word == MTIME_HI_WORD);
`endif

  // Next mtime: increment first, then written bytes override the result.
  always_comb begin
    w_mtime_nxt = r_mtime;
    if (w_tick) w_mtime_nxt = r_mtime + 64'd1;
`ifdef CLINT_MH_MTIME_WR_EN
    if (w_wr_mtlo) w_mtime_nxt[31:0]  = f_merge(w_mtime_nxt[31:0],  wdata, wstrb);
    if (w_wr_mthi) w_mtime_nxt[63:32] = f_merge(w_mtime_nxt[63:32], wdata, wstrb);
`endif
  end

  // Read mux over the current (pre-write) register values; unmapped -> error.
  always_comb begin
    w_rd_data = '0;
    w_rd_err  = 1'b1;
    for (int h = 0; h < NHART; h++) begin
      if (w_rd_word == 14'(h)) begin
        w_rd_data = {31'd0, r_msip[h]};
        w_rd_err  = 1'b0;
      end
      if ((raddr[15:14] == 2'b01) && (w_rd_cmp_idx == 11'(h))) begin
        w_rd_data = raddr[2] ? r_mtimecmp[h][63:32] : r_mtimecmp[h][31:0];
        w_rd_err  = 1'b0;
      end
    end
    if (w_rd_word == MTIME_LO_WORD) begin
      w_rd_data = r_mtime[31:0];
      w_rd_err  = 1'b0;
    end
    if (w_rd_word == MTIME_HI_WORD) begin
      w_rd_data = r_mtime[63:32];
      w_rd_err  = 1'b0;
    end
  end

  // Bus acknowledges and registered read response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wvalid <= 1'b0;
      r_rvalid <= 1'b0;
      r_rresp  <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_wvalid <= wready;
      r_rvalid <= rready;
      if (rready) begin
        r_rdata <= w_rd_data;
        r_rresp <= w_rd_err;
      end
    end
  end

  // Prescaler and the shared mtime counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_presc <= '0;
      r_mtime <= '0;
    end else begin
      if (timer_en) begin
        r_presc <= (r_presc == PMAX) ? '0 : r_presc + PW'(1);
      end
      r_mtime <= w_mtime_nxt;
    end
  end

  // Per-hart msip and mtimecmp registers with byte-strobed writes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_msip <= '0;
      for (int h = 0; h < NHART; h++) r_mtimecmp[h] <= '1;
    end else begin
      for (int h = 0; h < NHART; h++) begin
        if (w_wr_msip && (w_wr_word == 14'(h)) && wstrb[0]) begin
          r_msip[h] <= wdata[0];
        end
        if (w_wr_cmp && (w_wr_cmp_idx == 11'(h))) begin
          if (waddr[2]) begin
            r_mtimecmp[h][63:32] <= f_merge(r_mtimecmp[h][63:32], wdata, wstrb);
          end else begin
            r_mtimecmp[h][31:0]  <= f_merge(r_mtimecmp[h][31:0], wdata, wstrb);
          end
        end
      end
    end
  end

  // Registered interrupt outputs and the external-interrupt synchroniser.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_timer_irq <= '0;
      r_sw_irq    <= '0;
      r_ext_meta  <= '0;
      r_ex_irq    <= '0;
    end else begin
      for (int h = 0; h < NHART; h++) begin
        r_timer_irq[h] <= (r_mtime >= r_mtimecmp[h]);
      end
      r_sw_irq   <= r_msip;
      r_ext_meta <= ext_irq_in;
      r_ex_irq   <= r_ext_meta;
    end
  end

  assign wvalid    = r_wvalid;
  assign rvalid    = r_rvalid;
  assign rresp     = r_rresp;
  assign rdata     = r_rdata;
  assign timer_irq = r_timer_irq;
  assign sw_irq    = r_sw_irq;
  assign ex_irq    = r_ex_irq;

endmodule

// File: doc/clint_mh.md
# clint_mh

Multi-hart core-local interruptor for the srv32 platform, generalising the single-hart CLINT to `NHART` harts. It holds one shared 64-bit `mtime` with a programmable prescaler, plus per-hart `msip` and 64-bit `mtimecmp` registers. It also provides a per-hart synchronised external-interrupt path. It sits on the same wready/wvalid and rready/rvalid memory-mapped bus the core uses for peripherals.

## Interface
- `NHART`, 2, number of harts (1..8)
- `TICK_DIV`, 1, `clk` cycles per `mtime` increment while `timer_en`=1 (1..256)
- `clk` in 1: system clock
- `reset` in 1: asynchronous, active-high reset
- `timer_en` in 1: enables prescaler and `mtime` counting
- `wready` in 1: write request; sampled with `waddr`, `wdata`, `wstrb`
- `wvalid` out 1: write acknowledge
- `waddr` in 32: write byte address; offset taken from `[15:0]`
- `wdata` in 32: write data
- `wstrb` in 4: byte lane enables
- `rready` in 1: read request; sampled with `raddr`
- `rvalid` out 1: read data valid
- `raddr` in 32: read byte address; offset taken from `[15:0]`
- `rresp` out 1: 1 = unmapped address error
- `rdata` out 32: read data
- `ext_irq_in` in NHART: asynchronous external interrupt sources
- `timer_irq` out NHART: per-hart machine timer interrupt
- `sw_irq` out NHART: per-hart machine software interrupt
- `ex_irq` out NHART: per-hart synchronised external interrupt

## Operation
- Address map (offset = addr[15:0], word aligned; addr[1:0] ignored):
  - `msip[h]`: 0x0000+4h; bit 0 only is implemented, other bits read as 0.
  - `mtimecmp[h]` low/high words: 0x4000+8h and 0x4004+8h.
  - `mtime` low/high words: 0xBFF8 and 0xBFFC.
  - Any other offset, including harts ≥ NHART, is unmapped.
- Writes honour `wstrb` per byte. An unmapped write is ignored but still acknowledged.
- An unmapped read returns `rdata`=0 with `rresp`=1. A mapped read returns `rresp`=0.
- Prescaler:
  - Counts 0..TICK_DIV-1 only while `timer_en`=1, and holds when `timer_en`=0.
  - On wrap, `mtime` increments by 1, with full 64-bit carry from the low word into the high word.
  - When `TICK_DIV`=1, `mtime` increments every enabled cycle.
- `mtime` wraps from 0xFFFF_FFFF_FFFF_FFFF to 0.
- Simultaneous bus write to an `mtime` word and an increment: the written bytes take the written value. Unwritten bytes take the incremented value.
- `timer_irq[h]` is registered: 1 when the unsigned comparison `mtime >= mtimecmp[h]` holds, evaluated on the current register values.
- `sw_irq[h]` = `msip[h]` bit 0, registered.
- `ex_irq[h]` is `ext_irq_in[h]` passed through a 2-flop synchroniser.
- A read and a write in the same cycle are both serviced. The read returns the pre-write value.

## Timing
- Reset values:
  - All outputs 0.
  - `mtime`=0, prescaler=0, `msip`=0.
  - `mtimecmp[h]`=0xFFFF_FFFF_FFFF_FFFF, so no timer interrupt follows reset.
- Write handshake: `wready` high at edge N commits the write at edge N. `wvalid`=1 for exactly one cycle after edge N. Back-to-back requests each get one acknowledge pulse.
- Read handshake: `rready` high at edge N registers `rdata`/`rresp` at edge N. `rvalid`=1 for one cycle after N.
- `timer_irq` latency:
  - Asserts one cycle after the `mtime`/`mtimecmp` register update that satisfies the compare.
  - Deasserts one cycle after a `mtimecmp` write that makes the compare false.
  - A 32-bit half-write of `mtimecmp` may glitch `timer_irq` between the two halves. This is accepted; software writes the high word as all ones first.
- `sw_irq` follows an `msip` write one cycle later.
- `ex_irq` lags `ext_irq_in` by 2 cycles.
- Reset asserted mid-operation: all state returns to reset values immediately. A pending `wvalid`/`rvalid` is dropped.

## Configuration
- `CLINT_MH_MTIME_WR_EN`:
  - Defined: `mtime` words are writable as described above.
  - Undefined: `mtime` is read-only. Writes to 0xBFF8/0xBFFC are ignored but acknowledged with `wvalid`, and are not flagged as errors.

## Test plan
- Reset: release `reset`, NHART=2. Read 0x4000 and 0x4004 → both 0xFFFF_FFFF, `rresp`=0. Check `timer_irq`=0 and `sw_irq`=0.
- Prescaler: TICK_DIV=4, `timer_en`=1 for 40 cycles → `mtime` low reads 10. Hold `timer_en`=0 for 20 cycles → still 10.
- Compare: write `mtimecmp[1]` high=0, low=20 with `timer_en`=1, TICK_DIV=1 → `timer_irq[1]` rises one cycle after `mtime` reaches 20, while `timer_irq[0]` stays 0. Then write `mtimecmp[1]` low=0xFFFF_FFFF → `timer_irq[1]` drops next cycle.
- Carry/collision (with `CLINT_MH_MTIME_WR_EN`):
  - Write `mtime` low=0xFFFF_FFFF, high=0 → after one increment, high reads 1 and low reads 0.
  - Write low=5 with `wstrb`=0001 in a cycle that is also an increment cycle → low reads 5.
- Software IRQ and strobes:
  - Write 0x0004 with 1 → `sw_irq`=2'b10 one cycle later.
  - Write 0x0004 with 0 and `wstrb`=0000 → `sw_irq` unchanged.
- Errors and external interrupts:
  - Read 0x0008 with NHART=2 → `rdata`=0, `rresp`=1.
  - Write 0x1234 → `wvalid` pulses and no state changes.
  - Pulse `ext_irq_in[0]` → `ex_irq[0]` follows 2 cycles later.
